pacman_soc_gpio_in_irq: RTL and testbench
=========================================

Name: pacman_soc_gpio_in_irq

Overview:
- Parametrised Avalon-MM input PIO slave; successor to the single-bit read-only input port.
- Synchronises WIDTH asynchronous inputs, optionally debounces them, and captures edges into sticky bits.
- Raises a level interrupt to the SoC interrupt controller (e.g. for USB GPX or button/status lines).
- Readdata is registered, giving a fixed read latency of 1 clk.

Parameters:
- WIDTH, 8: number of input bits; legal range 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit; legal range 2..4.
- DEBOUNCE_CYCLES, 0: consecutive stable cycles required before the debounced value follows the input; 0 bypasses debounce; legal range 0..65535.
- EDGE_TYPE, 0: edge captured; 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- in_port  in  WIDTH  asynchronous external inputs
- readdata  out  32  registered read data
- irq  out  1  level interrupt, active-high

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All state clears on reset_n=0: sync chain, debounced value, debounce counters, irqmask, edge_capture, readdata, irq.
- Synchroniser: SYNC_STAGES flops per bit; the last stage is sync_in.
- Debounce, DEBOUNCE_CYCLES=0: deb = sync_in delayed by 1 clk.
- Debounce, DEBOUNCE_CYCLES=N>0, per-bit counter:
  - sync_in==deb: counter is held at 0.
  - sync_in!=deb: counter increments.
  - Counter reaches N-1 while the mismatch persists: deb toggles and the counter returns to 0.
  - A glitch shorter than N cycles never reaches deb.
  - Counter width is clog2(N+1).
- Edge detect: deb_d is deb delayed 1 clk.
  - EDGE_TYPE 0: ev = deb & ~deb_d
  - EDGE_TYPE 1: ev = ~deb & deb_d
  - EDGE_TYPE 2: ev = deb ^ deb_d
- Register map (word addresses):
  - 0 DATA: RO, bits [WIDTH-1:0] = deb, upper bits 0; writes ignored.
  - 1: reserved; reads 0, writes ignored.
  - 2 IRQMASK: RW, bits [WIDTH-1:0]; upper writedata bits are dropped.
  - 3 EDGECAP: RO sticky; a write of 1 to a bit clears that bit (W1C).
- Edge capture: edge_capture[i] is set on ev[i] regardless of the mask.
  - Simultaneous ev[i] and W1C of bit i: set wins, bit stays 1.
- Write: takes effect on the clk edge where chipselect=1 and write_n=0.
- Read: readdata is updated every clk from the address mux; there is no read strobe, and reads have no side effects.
  - Readdata reflects register state before any same-cycle write.
- irq = |(edge_capture & irqmask), registered; it asserts 1 clk after the capture bit sets.
- irq deasserts 1 clk after the last enabled bit clears, or after its mask bit is cleared.
- Total latency from in_port toggle to edge_capture set (DEBOUNCE_CYCLES=0): SYNC_STAGES+2 clk.
- Reset mid-debounce: the counter is discarded; after release, deb restarts from 0.
  - A high input at release yields a rising edge once it is debounced.

Decomposition:
- Package pacman_soc_gpio_pkg holds:
  - Address constants: ADDR_DATA=2'd0, ADDR_IRQMASK=2'd2, ADDR_EDGECAP=2'd3.
  - Edge-type constants: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
  - A clog2 function.
- Sub-module pacman_soc_gpio_debounce: one bit, with parameters SYNC_STAGES and DEBOUNCE_CYCLES; contains the sync chain, counter and deb output.
  - The top level instantiates it WIDTH times in a generate loop.

Test Plan:
- Reset/readback, WIDTH=8: hold in_port=8'hA5 in reset; release; wait 5 clk; read addr 0 -> 32'h000000A5. Read addr 3 -> 32'h000000A5 (rising edges out of reset). irq=0 (mask 0).
- Interrupt path, EDGE_TYPE=0: write IRQMASK=8'h01; pulse in_port[0] 0->1 -> edge_capture[0]=1 at SYNC_STAGES+2 clk, irq=1 one clk later. Write addr 3 data 1 -> irq=0 on the next clk.
- Masking: mask=8'h00; toggle in_port[3] rising -> EDGECAP reads 32'h08, irq stays 0. Write mask=8'h08 -> irq=1 after 1 clk.
- Debounce, DEBOUNCE_CYCLES=4: pulse in_port[1] high for 3 clk -> DATA bit1 stays 0, no capture. Hold high 6 clk -> DATA bit1=1, EDGECAP bit1=1.
- Set/clear collision: W1C of bit 2 issued in the same clk that ev[2] fires -> EDGECAP bit2 remains 1.
- EDGE_TYPE=2, WIDTH=32: toggle in_port 32'h0->32'hFFFFFFFF->32'h0 -> EDGECAP=32'hFFFFFFFF after each toggle. Address 1 always reads 0.

Source files
------------

// File: rtl/pacman_soc_gpio_pkg.sv
// rtl/pacman_soc_gpio_pkg.sv - shared constants and helpers for the GPIO input PIO
package pacman_soc_gpio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/pacman_soc_gpio_debounce.sv
// rtl/pacman_soc_gpio_debounce.sv - one-bit synchroniser with optional stable-count debounce
module pacman_soc_gpio_debounce
   import pacman_soc_gpio_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic deb
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_in;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
   end

   assign sync_in = sync_q[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) deb <= 1'b0;
            else          deb <= sync_in;
         end
      end else begin : g_debounce
         localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
         logic [CW-1:0] cnt;

         // deb flips on the Nth consecutive mismatching cycle; any agreement restarts the count
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt <= '0;
               deb <= 1'b0;
            end else if (sync_in == deb) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               cnt <= '0;
               deb <= ~deb;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/pacman_soc_gpio_in_irq.sv
// rtl/pacman_soc_gpio_in_irq.sv - Avalon-MM input PIO with edge capture and level interrupt
module pacman_soc_gpio_in_irq
   import pacman_soc_gpio_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_TYPE       = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] deb, deb_d, ev, w1c;
   logic [WIDTH-1:0] irqmask, edge_capture;
   logic [31:0]      rd_mux;
   logic             wr_en;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         pacman_soc_gpio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (in_port[i]),
            .deb     (deb[i])
         );
      end
   endgenerate

   assign wr_en = chipselect & ~write_n;
   assign w1c   = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

   always_comb begin
      ev = deb & ~deb_d;
      if (EDGE_TYPE == EDGE_FALL)     ev = ~deb & deb_d;
      else if (EDGE_TYPE == EDGE_ANY) ev = deb ^ deb_d;
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:    rd_mux[WIDTH-1:0] = deb;
         ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
         ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_capture;
         default:      rd_mux = '0;
      endcase
   end

   // A new event in the same cycle as its W1C keeps the bit set
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_d        <= '0;
         irqmask      <= '0;
         edge_capture <= '0;
         readdata     <= '0;
         irq          <= 1'b0;
      end else begin
         deb_d        <= deb;
         edge_capture <= (edge_capture & ~w1c) | ev;
         irq          <= |(edge_capture & irqmask);
         readdata     <= rd_mux;
         if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_pacman_soc_gpio_in_irq.sv
// tb/tb_pacman_soc_gpio_in_irq.sv - scoreboard bench over three configurations of the GPIO input PIO
module tb_pacman_soc_gpio_in_irq;

   typedef struct {
      int          dut;
      logic [31:0] rd;
      logic        irq;
      string       name;
   } item_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic [2:0]  cs;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in0, in1;
   logic [31:0] in2;
   logic [31:0] rd0, rd1, rd2;
   logic        irq0, irq1, irq2;

   item_t sb[$];
   logic  rd_mark = 1'b0;
   bit    done = 1'b0;
   bit    fin = 1'b0;
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   pacman_soc_gpio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]), .write_n(write_n),
      .writedata(writedata), .in_port(in0), .readdata(rd0), .irq(irq0));

   pacman_soc_gpio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]), .write_n(write_n),
      .writedata(writedata), .in_port(in1), .readdata(rd1), .irq(irq1));

   pacman_soc_gpio_in_irq #(.WIDTH(32), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]), .write_n(write_n),
      .writedata(writedata), .in_port(in2), .readdata(rd2), .irq(irq2));

   // Monitor: an item marked before a rising edge is compared after that edge
   initial begin
      logic        v;
      item_t       it;
      logic [31:0] act_rd;
      logic        act_irq;
      forever begin
         @(posedge clk);
         v = rd_mark;
         @(negedge clk);
         if (v) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_underflow: sample with no expected item");
            end else begin
               it = sb.pop_front();
               act_rd  = (it.dut == 0) ? rd0  : (it.dut == 1) ? rd1  : rd2;
               act_irq = (it.dut == 0) ? irq0 : (it.dut == 1) ? irq1 : irq2;
               checks += 2;
               if (act_rd !== it.rd) begin
                  errors++;
                  $display("FAIL %s: readdata=%h expected %h", it.name, act_rd, it.rd);
               end
               if (act_irq !== it.irq) begin
                  errors++;
                  $display("FAIL %s_irq: irq=%b expected %b", it.name, act_irq, it.irq);
               end
            end
         end
         if (done && !fin) begin
            checks++;
            if (sb.size() != 0) begin
               errors++;
               $display("FAIL scoreboard_leftover: %0d items left expected 0", sb.size());
            end
            fin = 1'b1;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus(input int dut, input logic [1:0] a, input bit wr, input logic [31:0] wd,
                      input bit chk, input logic [31:0] exp_rd, input logic exp_irq, input string name);
      item_t it;
      address   = a;
      writedata = wd;
      if (wr) begin
         cs      = 3'(1 << dut);
         write_n = 1'b0;
      end
      if (chk) begin
         it.dut  = dut;
         it.rd   = exp_rd;
         it.irq  = exp_irq;
         it.name = name;
         sb.push_back(it);
         rd_mark = 1'b1;
      end
      tick(1);
      cs      = 3'b000;
      write_n = 1'b1;
      rd_mark = 1'b0;
   endtask

   task automatic rd(input int dut, input logic [1:0] a, input logic [31:0] e, input logic ei, input string name);
      bus(dut, a, 1'b0, 32'h0, 1'b1, e, ei, name);
   endtask

   task automatic wr(input int dut, input logic [1:0] a, input logic [31:0] d);
      bus(dut, a, 1'b1, d, 1'b0, 32'h0, 1'b0, "");
   endtask

   task automatic wrc(input int dut, input logic [1:0] a, input logic [31:0] d,
                      input logic [31:0] e, input logic ei, input string name);
      bus(dut, a, 1'b1, d, 1'b1, e, ei, name);
   endtask

   initial begin
      reset_n = 1'b0; address = 2'd0; cs = 3'b000; write_n = 1'b1; writedata = 32'h0;
      in0 = 8'hA5; in1 = 8'h00; in2 = 32'h0;
      tick(3);
      rd(0, 2'd0, 32'h0, 1'b0, "reset_readdata");
      reset_n = 1'b1;
      tick(5);
      rd(0, 2'd0, 32'h0000_00A5, 1'b0, "post_reset_data");
      rd(0, 2'd3, 32'h0000_00A5, 1'b0, "post_reset_edgecap");
      rd(0, 2'd1, 32'h0, 1'b0, "reserved_d0");

      // interrupt path, exact capture latency
      wrc(0, 2'd3, 32'hFF, 32'h0000_00A5, 1'b0, "w1c_all_prewrite");
      wrc(0, 2'd2, 32'h1234_5601, 32'h0, 1'b0, "mask_prewrite");
      rd(0, 2'd2, 32'h01, 1'b0, "mask_upper_dropped");
      in0 = 8'hA4;
      tick(6);
      rd(0, 2'd3, 32'h0, 1'b0, "falling_ignored");
      in0 = 8'hA5;
      tick(3);
      rd(0, 2'd3, 32'h0, 1'b0, "cap_before_latency");
      rd(0, 2'd3, 32'h01, 1'b1, "cap_at_latency");
      wrc(0, 2'd3, 32'h01, 32'h01, 1'b1, "w1c_bit0_prewrite");
      rd(0, 2'd3, 32'h0, 1'b0, "w1c_bit0_cleared");

      // masking
      wr(0, 2'd2, 32'h0);
      in0 = 8'hAD;
      tick(6);
      rd(0, 2'd3, 32'h08, 1'b0, "masked_capture");
      wrc(0, 2'd2, 32'h08, 32'h0, 1'b0, "unmask_prewrite");
      rd(0, 2'd2, 32'h08, 1'b1, "unmask_irq");

      // set/clear collision on bit 2
      wr(0, 2'd3, 32'hFF);
      wr(0, 2'd2, 32'h0);
      in0 = 8'hA9;
      tick(6);
      in0 = 8'hAD;
      tick(3);
      wrc(0, 2'd3, 32'h04, 32'h0, 1'b0, "collision_prewrite");
      rd(0, 2'd3, 32'h04, 1'b0, "collision_set_wins");

      // debounce, N=4
      in1 = 8'h02;
      tick(3);
      in1 = 8'h00;
      tick(8);
      rd(1, 2'd0, 32'h0, 1'b0, "glitch_data");
      rd(1, 2'd3, 32'h0, 1'b0, "glitch_edgecap");
      in1 = 8'h02;
      tick(5);
      rd(1, 2'd0, 32'h0, 1'b0, "deb_before_n");
      rd(1, 2'd0, 32'h02, 1'b0, "deb_at_n");
      rd(1, 2'd3, 32'h02, 1'b0, "deb_edgecap");

      // any-edge, 32 bits, 3 sync stages
      in2 = 32'hFFFF_FFFF;
      tick(4);
      rd(2, 2'd3, 32'h0, 1'b0, "any_rise_before");
      rd(2, 2'd3, 32'hFFFF_FFFF, 1'b0, "any_rise_edgecap");
      rd(2, 2'd1, 32'h0, 1'b0, "reserved_d2_high");
      rd(2, 2'd0, 32'hFFFF_FFFF, 1'b0, "any_data_high");
      wr(2, 2'd3, 32'hFFFF_FFFF);
      in2 = 32'h0;
      tick(8);
      rd(2, 2'd3, 32'hFFFF_FFFF, 1'b0, "any_fall_edgecap");
      rd(2, 2'd0, 32'h0, 1'b0, "any_data_low");
      rd(2, 2'd1, 32'h0, 1'b0, "reserved_d2_low");

      tick(2);
      done = 1'b1;
      repeat (3) @(posedge clk);
      if (!fin) begin
         errors++;
         $display("FAIL monitor_final: final check not reached");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
